// File: rtl/ibex_pkg.sv
// Shared types for the sequential multiplier.
// Holds the FSM state encoding and the shift-add pass count.
package ibex_pkg;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_ITER = 2'd1,
    MUL_CORR = 2'd2,
    MUL_DONE = 2'd3
  } mul_seq_state_e;

  localparam int MUL_SEQ_ITERS = 32;

endpackage

// File: rtl/ibex_mul_seq_carry.sv
// Rebuilds the carry-out of a 32-bit add from the operand MSBs and the sum MSB.
// Ports: x31/y31 operand MSBs, s31 sum MSB, carry rebuilt carry-out.
module ibex_mul_seq_carry (
  input  logic x31,
  input  logic y31,
  input  logic s31,
  output logic carry
);

  // Both MSBs set always carry; exactly one set carries when the sum MSB wrapped to 0.
  assign carry = (x31 & y31) | ((x31 ^ y31) & ~s31);

endmodule

// File: rtl/ibex_mul_seq.sv
// Sequential radix-2 32x32 multiplier (MUL/MULH/MULHSU/MULHU) on the shared adder.
// Ports: clk_i/rst_i (sync, active-high); valid_i/ready_o request handshake;
//  mul_op_i high-word select; signed_mode_i {b_signed,a_signed}; op_a_i/op_b_i;
//  kill_i flush; adder_busy_o, adder_op_a_o/adder_op_b_o, adder_result_i shared adder;
//  valid_o/ready_i/result_o result handshake.
//  Define MUL_SEQ_FAST_ZERO_EN to finish zero-operand requests without using the adder.
module ibex_mul_seq
  import ibex_pkg::*;
#(
  parameter int AdderLatency = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic        mul_op_i,
  input  logic [1:0]  signed_mode_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        kill_i,
  output logic        adder_busy_o,
  output logic [31:0] adder_op_a_o,
  output logic [31:0] adder_op_b_o,
  input  logic [31:0] adder_result_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o
);

  if (AdderLatency < 1 || AdderLatency > 2) begin : g_bad_latency
    $error("ibex_mul_seq: AdderLatency must be 1 or 2");
  end

  localparam logic [1:0] LAT = 2'(AdderLatency);
  localparam logic [4:0] LAST_ITER = 5'(MUL_SEQ_ITERS - 1);

  mul_seq_state_e state;
  mul_seq_state_e state_next;

  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] mcand;
  logic [31:0] opb;
  logic        mop;
  logic        need_a;
  logic        need_b;
  logic        half;
  logic [1:0]  phase;
  logic [4:0]  iter;
  logic        x31;
  logic        y31;

  logic        accept;
  logic        zero_fast;
  logic        drive;
  logic        capture;
  logic        carry;
  logic [31:0] sub_val;

  assign accept  = valid_i & ready_o & ~kill_i;
  assign drive   = adder_busy_o & (phase == 2'd0);
  assign capture = adder_busy_o & (phase == LAT);
  // Pending subtracts run a-side first: hi -= op_b, then hi -= op_a.
  assign sub_val = need_a ? opb : mcand;

`ifdef MUL_SEQ_FAST_ZERO_EN
  assign zero_fast = (op_a_i == 32'd0) | (op_b_i == 32'd0);
`else
  assign zero_fast = 1'b0;
`endif

  ibex_mul_seq_carry u_carry (
    .x31   (x31),
    .y31   (y31),
    .s31   (adder_result_i[31]),
    .carry (carry)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= MUL_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      MUL_IDLE: begin
        if (accept) begin
          state_next = zero_fast ? MUL_DONE : MUL_ITER;
        end
      end
      MUL_ITER: begin
        if (capture && iter == LAST_ITER) begin
          state_next = (need_a | need_b) ? MUL_CORR : MUL_DONE;
        end
      end
      MUL_CORR: begin
        // After the second half of a subtract, finish unless both were pending.
        if (capture && half && !(need_a && need_b)) begin
          state_next = MUL_DONE;
        end
      end
      MUL_DONE: begin
        if (ready_i) begin
          state_next = MUL_IDLE;
        end
      end
      default: state_next = MUL_IDLE;
    endcase
    if (kill_i) begin
      state_next = MUL_IDLE;
    end
  end

  always_comb begin
    ready_o      = (state == MUL_IDLE);
    adder_busy_o = (state == MUL_ITER) | (state == MUL_CORR);
    valid_o      = (state == MUL_DONE);
    result_o     = 32'd0;
    adder_op_a_o = 32'd0;
    adder_op_b_o = 32'd0;
    if (state == MUL_DONE) begin
      result_o = mop ? hi : lo;
    end
    if (state == MUL_ITER && phase == 2'd0) begin
      adder_op_a_o = hi;
      adder_op_b_o = lo[0] ? mcand : 32'd0;
    end
    if (state == MUL_CORR && phase == 2'd0) begin
      adder_op_a_o = hi;
      adder_op_b_o = half ? 32'd1 : ~sub_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hi     <= 32'd0;
      lo     <= 32'd0;
      mcand  <= 32'd0;
      opb    <= 32'd0;
      mop    <= 1'b0;
      need_a <= 1'b0;
      need_b <= 1'b0;
      half   <= 1'b0;
      phase  <= 2'd0;
      iter   <= 5'd0;
      x31    <= 1'b0;
      y31    <= 1'b0;
    end else if (kill_i) begin
      need_a <= 1'b0;
      need_b <= 1'b0;
      half   <= 1'b0;
      phase  <= 2'd0;
      iter   <= 5'd0;
    end else begin
      if (accept) begin
        hi     <= 32'd0;
        lo     <= zero_fast ? 32'd0 : op_b_i;
        mcand  <= op_a_i;
        opb    <= op_b_i;
        mop    <= mul_op_i;
        // High word of a signed operand needs the unsigned product corrected.
        need_a <= mul_op_i & signed_mode_i[0] & op_a_i[31] & ~zero_fast;
        need_b <= mul_op_i & signed_mode_i[1] & op_b_i[31] & ~zero_fast;
        half   <= 1'b0;
        phase  <= 2'd0;
        iter   <= 5'd0;
      end
      if (adder_busy_o) begin
        phase <= capture ? 2'd0 : phase + 2'd1;
      end
      if (drive) begin
        x31 <= adder_op_a_o[31];
        y31 <= adder_op_b_o[31];
      end
      if (capture && state == MUL_ITER) begin
        hi   <= {carry, adder_result_i[31:1]};
        lo   <= {adder_result_i[0], lo[31:1]};
        iter <= iter + 5'd1;
      end
      if (capture && state == MUL_CORR) begin
        hi <= adder_result_i;
        if (half) begin
          half <= 1'b0;
          if (need_a) begin
            need_a <= 1'b0;
          end else begin
            need_b <= 1'b0;
          end
        end else begin
          half <= 1'b1;
        end
      end
    end
  end

  a_busy_not_ready: assert property (
    @(posedge clk_i) !(adder_busy_o && ready_o)
  );

  a_valid_stable: assert property (
    @(posedge clk_i) disable iff (rst_i)
    (valid_o && !ready_i && !kill_i) |=> (valid_o && $stable(result_o))
  );

endmodule
